mem_bank_sequencer: RTL and testbench

MEM_BANK_SEQUENCER -- requirements
Module: mem_bank_sequencer

---
 rtl/mem_bank_sequencer.sv | 142 ++++++++++++++
 tb/tb_mem_bank_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_sequencer.sv
// Sequences host writes and clear sweeps (automatic after reset, or on request) onto a
// registered banked memory write port; reads pass straight through with a delayed valid.
module mem_bank_sequencer #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH = 2,
  parameter int NUM_BANKS = 1,
  parameter int OUTPUT_DELAY = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [BW-1:0]         host_bank,
  input  logic [AW-1:0]         host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  rd_req,
  input  logic [BW-1:0]         rd_bank,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_wea,
  output logic [BW-1:0]         mem_banka,
  output logic [AW-1:0]         mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dia,
  output logic                  mem_reb,
  output logic [BW-1:0]         mem_bankb,
  output logic [AW-1:0]         mem_addrb,
  input  logic [DATA_WIDTH-1:0] mem_dob
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t                  state_reg, state_next;
  logic [BW-1:0]           sweep_bank_reg, sweep_bank_next;
  logic [AW-1:0]           sweep_addr_reg, sweep_addr_next;
  logic                    wr_en_next;
  logic [BW-1:0]           wr_bank_next;
  logic [AW-1:0]           wr_addr_next;
  logic [DATA_WIDTH-1:0]   wr_data_next;
  logic                    done_next;
  logic                    sweep_last;

  assign sweep_last    = (sweep_bank_reg == LAST_BANK) && (sweep_addr_reg == LAST_ADDR);
  assign host_wr_ready = (state_reg == IDLE);
  // Busy stays up through the cycle the final sweep write is on the port.
  assign clear_busy    = (state_reg == CLEAR) || clear_done;

  always_comb begin
    state_next      = state_reg;
    sweep_bank_next = sweep_bank_reg;
    sweep_addr_next = sweep_addr_reg;
    wr_en_next      = 1'b0;
    wr_bank_next    = mem_banka;
    wr_addr_next    = mem_addra;
    wr_data_next    = mem_dia;
    done_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host_wr_valid) begin
          wr_en_next   = 1'b1;
          wr_bank_next = host_bank;
          wr_addr_next = host_addr;
          wr_data_next = host_data;
        end
        if (clear_start) state_next = CLEAR;
      end
      CLEAR: begin
        wr_en_next   = 1'b1;
        wr_bank_next = sweep_bank_reg;
        wr_addr_next = sweep_addr_reg;
        wr_data_next = CLEAR_VALUE;
        if (sweep_last) begin
          done_next       = 1'b1;
          state_next      = IDLE;
          sweep_bank_next = '0;
          sweep_addr_next = '0;
        end else if (sweep_addr_reg == LAST_ADDR) begin
          sweep_addr_next = '0;
          sweep_bank_next = sweep_bank_reg + BW'(1);
        end else begin
          sweep_addr_next = sweep_addr_reg + AW'(1);
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= CLEAR;
      sweep_bank_reg <= '0;
      sweep_addr_reg <= '0;
      mem_wea        <= 1'b0;
      mem_banka      <= '0;
      mem_addra      <= '0;
      mem_dia        <= '0;
      clear_done     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sweep_bank_reg <= sweep_bank_next;
      sweep_addr_reg <= sweep_addr_next;
      mem_wea        <= wr_en_next;
      mem_banka      <= wr_bank_next;
      mem_addra      <= wr_addr_next;
      mem_dia        <= wr_data_next;
      clear_done     <= done_next;
    end
  end

  assign mem_reb   = rd_req;
  assign mem_bankb = rd_bank;
  assign mem_addrb = rd_addr;
  assign rd_data   = mem_dob;

  generate
    if (OUTPUT_DELAY == 0) begin : g_rd_comb
      assign rd_valid = rd_req;
    end else begin : g_rd_pipe
      // Valid tracks the attached memory's read latency; data is never captured here.
      logic [OUTPUT_DELAY-1:0] rd_pipe_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_pipe_reg <= '0;
        end else begin
          rd_pipe_reg[0] <= rd_req;
          for (int i = 1; i < OUTPUT_DELAY; i++) rd_pipe_reg[i] <= rd_pipe_reg[i-1];
        end
      end
      assign rd_valid = rd_pipe_reg[OUTPUT_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_mem_bank_sequencer.sv
// Bench for mem_bank_sequencer: 3 banks x 4 words, 2-cycle memory, clear value 6.
module tb_mem_bank_sequencer;
  localparam int NB = 3;
  localparam int D  = 4;
  localparam int OD = 2;
  localparam logic [2:0] CV = 3'd6;

  logic       clk;
  logic       reset_n;
  logic       host_wr_valid, host_wr_ready;
  logic [1:0] host_bank, host_addr;
  logic [2:0] host_data;
  logic       clear_start, clear_busy, clear_done;
  logic       rd_req, rd_valid;
  logic [1:0] rd_bank, rd_addr;
  logic [2:0] rd_data;
  logic       mem_wea, mem_reb;
  logic [1:0] mem_banka, mem_addra, mem_bankb, mem_addrb;
  logic [2:0] mem_dia, mem_dob;

  mem_bank_sequencer #(
    .DATA_WIDTH(3), .DEPTH(D), .NUM_BANKS(NB), .OUTPUT_DELAY(OD), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_bank(host_bank), .host_addr(host_addr), .host_data(host_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_wea(mem_wea), .mem_banka(mem_banka), .mem_addra(mem_addra), .mem_dia(mem_dia),
    .mem_reb(mem_reb), .mem_bankb(mem_bankb), .mem_addrb(mem_addrb), .mem_dob(mem_dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory: read-before-write array with a two-stage output register.
  logic [2:0] bmem [0:2][0:3];
  logic [2:0] dob_s0, dob_s1;
  always @(posedge clk) begin
    dob_s0 <= bmem[mem_bankb][mem_addrb];
    dob_s1 <= dob_s0;
    if (mem_wea) bmem[mem_banka][mem_addra] <= mem_dia;
  end
  assign mem_dob = dob_s1;

  // Reference model: sweep as a linear location index k -> (k / D, k % D).
  bit         m_sweep = 1'b1;
  int         m_k = 0;
  bit         e_wea = 1'b0, e_done = 1'b0;
  logic [1:0] e_bank = '0, e_addr = '0;
  logic [2:0] e_data = '0;
  logic [2:0] m_mem [0:2][0:3];
  bit         req_hist [64];
  logic [2:0] data_hist [64];
  logic [5:0] ptr = '0;
  bit         exp_rv;
  logic [2:0] exp_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sweep <= 1'b1;
      m_k     <= 0;
      e_wea   <= 1'b0;
      e_done  <= 1'b0;
      for (int i = 0; i < 64; i++) req_hist[i] <= 1'b0;
    end else begin
      req_hist[ptr]  <= rd_req;
      data_hist[ptr] <= m_mem[rd_bank][rd_addr];
      ptr            <= ptr + 6'd1;
      if (e_wea) m_mem[e_bank][e_addr] <= e_data;
      if (m_sweep) begin
        e_wea  <= 1'b1;
        e_bank <= 2'(m_k / D);
        e_addr <= 2'(m_k % D);
        e_data <= CV;
        e_done <= (m_k == NB * D - 1);
        if (m_k == NB * D - 1) begin
          m_sweep <= 1'b0;
          m_k     <= 0;
        end else begin
          m_k <= m_k + 1;
        end
      end else begin
        e_done <= 1'b0;
        e_wea  <= host_wr_valid;
        if (host_wr_valid) begin
          e_bank <= host_bank;
          e_addr <= host_addr;
          e_data <= host_data;
        end
        if (clear_start) m_sweep <= 1'b1;
      end
    end
  end
  assign exp_rv    = req_hist[ptr - 6'(OD)];
  assign exp_rdata = data_hist[ptr - 6'(OD)];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_wea", int'(mem_wea), int'(e_wea));
    check("cyc_done", int'(clear_done), int'(e_done));
    check("cyc_busy", int'(clear_busy), int'(m_sweep || e_done));
    check("cyc_ready", int'(host_wr_ready), int'(!m_sweep));
    check("cyc_rd_valid", int'(rd_valid), int'(exp_rv));
    check("cyc_reb", int'(mem_reb), int'(rd_req));
    check("cyc_bankb", int'(mem_bankb), int'(rd_bank));
    check("cyc_addrb", int'(mem_addrb), int'(rd_addr));
    if (e_wea) begin
      check("cyc_banka", int'(mem_banka), int'(e_bank));
      check("cyc_addra", int'(mem_addra), int'(e_addr));
      check("cyc_dia", int'(mem_dia), int'(e_data));
    end
    if (exp_rv) check("cyc_rd_data", int'(rd_data), int'(exp_rdata));
  end

  int wea_log [32], bank_log [32], addr_log [32], data_log [32];
  int done_log [32], busy_log [32], ready_log [32], valid_log [32], rdata_log [32];

  task automatic sample(input int i);
    wea_log[i]   = int'(mem_wea);
    bank_log[i]  = int'(mem_banka);
    addr_log[i]  = int'(mem_addra);
    data_log[i]  = int'(mem_dia);
    done_log[i]  = int'(clear_done);
    busy_log[i]  = int'(clear_busy);
    ready_log[i] = int'(host_wr_ready);
    valid_log[i] = int'(rd_valid);
    rdata_log[i] = int'(rd_data);
  endtask

  function automatic int count_log(input int arr [32], input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += arr[i];
    return n;
  endfunction

  task automatic check_write(input string name, input int i, input int b, input int a, input int d);
    check({name, "_wea"}, wea_log[i], 1);
    check({name, "_bank"}, bank_log[i], b);
    check({name, "_addr"}, addr_log[i], a);
    check({name, "_data"}, data_log[i], d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    reset_n = 1'b0; host_wr_valid = 1'b0; host_bank = '0; host_addr = '0; host_data = '0;
    clear_start = 1'b0; rd_req = 1'b0; rd_bank = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wea", int'(mem_wea), 0);
    check("rst_banka", int'(mem_banka), 0);
    check("rst_dia", int'(mem_dia), 0);
    check("rst_done", int'(clear_done), 0);
    check("rst_busy", int'(clear_busy), 1);
    check("rst_ready", int'(host_wr_ready), 0);

    // Power-on sweep after reset release.
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 0) reset_n = 1'b1;
      @(negedge clk); sample(i);
    end
    check("init_idle_wea", wea_log[0], 0);
    check_write("init_first", 1, 0, 0, 6);
    check_write("init_k3", 4, 0, 3, 6);
    check_write("init_k4", 5, 1, 0, 6);
    check_write("init_last", 12, 2, 3, 6);
    check("init_done_last", done_log[12], 1);
    check("init_ready_last", ready_log[12], 1);
    check("init_after_wea", wea_log[13], 0);
    check("init_after_busy", busy_log[13], 0);
    check("init_count", count_log(wea_log, 0, 13), 12);
    check("init_done_count", count_log(done_log, 0, 13), 1);

    // Single host write in IDLE.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin host_wr_valid = 1'b1; host_bank = 2'd1; host_addr = 2'd2; host_data = 3'd5; end
      if (i == 1) host_wr_valid = 1'b0;
      @(negedge clk); sample(i);
    end
    check_write("host", 1, 1, 2, 5);
    check("host_after_wea", wea_log[2], 0);

    // Requested sweep with a redundant clear_start mid-sweep and a read during it.
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      clear_start = (i == 0 || i == 6);
      rd_req = (i == 3); rd_bank = 2'd2; rd_addr = 2'd0;
      @(negedge clk); sample(i);
    end
    check("restart_ready_c1", ready_log[1], 0);
    check_write("restart_first", 2, 0, 0, 6);
    check("restart_done13", done_log[13], 1);
    check("restart_after_wea", wea_log[14], 0);
    check("restart_count", count_log(wea_log, 0, 17), 12);
    check("restart_done_count", count_log(done_log, 0, 17), 1);

    // clear_start together with a host write, then a host write held through the sweep.
    acc = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        clear_start = 1'b1; host_wr_valid = 1'b1; host_bank = 2'd2; host_addr = 2'd1; host_data = 3'd7;
      end
      if (i == 1) begin
        clear_start = 1'b0; host_bank = 2'd0; host_addr = 2'd3; host_data = 3'd4;
      end
      if (acc) host_wr_valid = 1'b0;
      @(negedge clk); sample(i);
      if (i >= 1 && host_wr_valid && host_wr_ready) acc = 1'b1;
    end
    check_write("combo_host", 1, 2, 1, 7);
    check("combo_ready_held", count_log(ready_log, 1, 12), 0);
    check("combo_done13", done_log[13], 1);
    check("combo_ready13", ready_log[13], 1);
    check_write("combo_late", 14, 0, 3, 4);
    check("combo_after_wea", wea_log[15], 0);
    check("combo_count", count_log(wea_log, 0, 17), 14);

    // Back-to-back reads with a two-cycle memory.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rd_req = (i < 2);
      rd_bank = (i == 0) ? 2'd2 : 2'd0;
      rd_addr = (i == 0) ? 2'd1 : 2'd3;
      @(negedge clk); sample(i);
    end
    check("rd_valid_c0", valid_log[0], 0);
    check("rd_valid_c1", valid_log[1], 0);
    check("rd_valid_c2", valid_log[2], 1);
    check("rd_valid_c3", valid_log[3], 1);
    check("rd_valid_c4", valid_log[4], 0);
    check("rd_data_c2", rdata_log[2], 6);
    check("rd_data_c3", rdata_log[3], 4);

    // Reset asserted while sweep location 5 is on the write port.
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      clear_start = (i == 0);
      if (i == 8) reset_n = 1'b1;
      @(negedge clk); sample(i);
      if (i == 7) begin
        #2 reset_n = 1'b0;
        #1;
        check("midrst_wea", int'(mem_wea), 0);
        check("midrst_banka", int'(mem_banka), 0);
        check("midrst_addra", int'(mem_addra), 0);
        check("midrst_dia", int'(mem_dia), 0);
        check("midrst_busy", int'(clear_busy), 1);
        check("midrst_ready", int'(host_wr_ready), 0);
      end
    end
    check_write("midrst_k5", 7, 1, 1, 6);
    check("midrst_held_wea", wea_log[8], 0);
    check_write("midrst_restart", 9, 0, 0, 6);
    check_write("midrst_last", 20, 2, 3, 6);
    check("midrst_done20", done_log[20], 1);
    check("midrst_count", count_log(wea_log, 9, 21), 12);
    check("midrst_done_count", count_log(done_log, 0, 21), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
